// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router packet reader.
//   rd_state_e          reader FSM states
//   LEN_MSB/LEN_LSB     payload length field of the header byte
//   ADDR_MSB/ADDR_LSB   destination field of the header byte
//   ERRCNT_W            width of the error counter output
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY
  } rd_state_e;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ERRCNT_W = 8;

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// router_skid_buf: 2-entry byte FIFO between the router FIFO read port and
// the packet stream output.
//   clock, resetn  clock, async active-low reset
//   flush          drop all buffered bytes
//   push/push_data write one byte (never while full)
//   pop            remove the head byte (never while empty)
//   head           oldest buffered byte
//   empty          no byte buffered
//   occ            number of buffered bytes (0..2)
module router_skid_buf (
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic [1:0] occ
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign occ   = count;

endmodule

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: reads header/payload/parity packets from the router FIFO
// (one-cycle read latency) and presents them as a valid/ready byte stream.
// Optional feature: define ROUTER_PKT_READER_ERRCNT_EN to enable the
// saturating error counter; otherwise err_count is tied to zero.
//   clock, resetn        clock, async active-low reset
//   fifo_empty           router FIFO empty flag
//   fifo_data            router FIFO data, valid the cycle after a read
//   fifo_read_enb        router FIFO read strobe
//   m_data/m_valid/m_ready  output byte stream handshake
//   m_sop / m_eop        header beat / parity beat markers
//   parity_err           pulse after a parity beat whose packet XOR != 0
//   pkt_abort            pulse after STALL_LIMIT starved cycles mid-packet
//   err_count            saturating count of parity_err and pkt_abort pulses
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 30
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                fifo_empty,
  input  logic [7:0]          fifo_data,
  output logic                fifo_read_enb,
  output logic [7:0]          m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_sop,
  output logic                m_eop,
  output logic                parity_err,
  output logic                pkt_abort,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

  rd_state_e          state, state_nxt;
  logic               rd_d;
  logic [6:0]         fetch_cnt;
  logic               hdr_known;
  logic [5:0]         fetch_len;
  logic [6:0]         pkt_total;
  logic [5:0]         remain;
  logic [7:0]         acc;
  logic [STALL_W-1:0] stall_cnt;
  logic               more_to_fetch;
  logic               outstanding;
  logic               starved;
  logic               abort;
  logic               accept;
  logic [7:0]         buf_head;
  logic               buf_empty;
  logic [1:0]         buf_occ;

  router_skid_buf u_skid (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (abort),
    .push      (rd_d),
    .push_data (fifo_data),
    .pop       (accept),
    .head      (buf_head),
    .empty     (buf_empty),
    .occ       (buf_occ)
  );

  // Until the header has landed only one byte (the header itself) may be
  // fetched; after that the packet is known to be L+2 bytes long, so at
  // least one byte is always still owed while the header is in flight.
  always_comb begin
    pkt_total     = {1'b0, fetch_len} + 7'd2;
    more_to_fetch = hdr_known ? (fetch_cnt < pkt_total) : (fetch_cnt == '0);
    outstanding   = !hdr_known || (fetch_cnt < pkt_total);
    starved       = (state != IDLE) && fifo_empty && outstanding;
    abort         = starved && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    fifo_read_enb = (state != IDLE) && !fifo_empty && more_to_fetch &&
                    ((buf_occ + {1'b0, rd_d}) < 2'd2);
    m_valid       = !buf_empty;
    accept        = m_valid && m_ready;
    m_data        = m_valid ? buf_head : '0;
    m_sop         = m_valid && (state == HDR);
    m_eop         = m_valid && (state == PARITY);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = HDR;
      HDR:     if (accept) state_nxt = (hdr_len(m_data) == '0) ? PARITY : PAYLOAD;
      PAYLOAD: if (accept && remain == 6'd1) state_nxt = PARITY;
      PARITY:  if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_d       <= 1'b0;
      fetch_cnt  <= '0;
      hdr_known  <= 1'b0;
      fetch_len  <= '0;
      remain     <= '0;
      acc        <= '0;
      stall_cnt  <= '0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      rd_d       <= fifo_read_enb;
      pkt_abort  <= abort;
      parity_err <= accept && (state == PARITY) && ((acc ^ m_data) != '0);
      stall_cnt  <= (starved && !abort) ? stall_cnt + STALL_W'(1) : '0;

      if (state == IDLE || abort) begin
        fetch_cnt <= '0;
        hdr_known <= 1'b0;
        fetch_len <= '0;
      end else begin
        if (fifo_read_enb) fetch_cnt <= fetch_cnt + 7'd1;
        if (rd_d && !hdr_known) begin
          hdr_known <= 1'b1;
          fetch_len <= hdr_len(fifo_data);
        end
      end

      if (accept) begin
        if (state == HDR) begin
          remain <= hdr_len(m_data);
          acc    <= m_data;
        end else begin
          if (state == PAYLOAD) remain <= remain - 6'd1;
          acc <= acc ^ m_data;
        end
      end
    end
  end

`ifdef ROUTER_PKT_READER_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) err_q <= '0;
    else if ((parity_err || pkt_abort) && (err_q != '1)) err_q <= err_q + ERRCNT_W'(1);
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule
